flg_sweep_ctrl: RTL and testbench
=================================

# flg_sweep_ctrl

Delay-sweep controller for the flanger: generates the per-sample tap delay that drives the variable delay line (`var_del`). The fixed-frequency cosine NCO is replaced by a configurable triangle sweep between a programmable minimum and maximum delay, at a programmable rate. Configuration is accepted through a valid/ready handshake and applied only on sample boundaries. A park sequence returns the tap smoothly to the minimum delay when the effect is disabled.

## Interface
- `DEL_WIDTH`, 9: delay width in samples; must match the `var_del` depth of 512.
- `FRAC_WIDTH`, 7: fractional bits of the sweep position.
- `STEP_WIDTH`, 12: width of the rate word, in units of 2^-FRAC_WIDTH samples per sample.
- `RST_MIN_DEL`, 16: minimum delay after reset.
- `RST_MAX_DEL`, 255: maximum delay after reset.
- `RST_STEP`, 64: rate word after reset.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: sweep enable, sampled only on `smp_i`.
- `smp_i` in 1: sample strobe; wire to the datapath `vld_i`.
- `cfg_min` in DEL_WIDTH: requested minimum delay.
- `cfg_max` in DEL_WIDTH: requested maximum delay.
- `cfg_step` in STEP_WIDTH: requested rate.
- `cfg_vld` in 1: configuration valid.
- `cfg_rdy` out 1: configuration ready; high when no configuration is pending.
- `del_o` out DEL_WIDTH: tap delay for `var_del`.
- `del_vld` out 1: one-cycle pulse when `del_o` has been updated.
- `cyc_o` out 1: one-cycle pulse, coincident with `del_vld`, when the sweep turns at the minimum.

## Operation
**Position register**
- `pos` is DEL_WIDTH+FRAC_WIDTH bits wide, unsigned.
- `del_o` = `pos[MSB -: DEL_WIDTH]`, truncated (no rounding).

**States.** Transitions are evaluated only on `smp_i`.
- IDLE: `pos` is held at min. If `en`=1, go to UP.
- UP: `nxt = pos + step`. If `nxt >= max<<F`, set `pos = max<<F` and go to DOWN; otherwise `pos = nxt`. If `en`=0, go to PARK instead of stepping.
- DOWN: `nxt = pos - step`, computed with a borrow bit. If there is a borrow or `nxt <= min<<F`, set `pos = min<<F`, pulse `cyc_o`, and go to UP; otherwise `pos = nxt`. If `en`=0, go to PARK.
- PARK: same arithmetic as DOWN. On reaching min, go to IDLE with no `cyc_o` pulse. If `en`=1, go to DOWN and continue the current step.

**Step behaviour**
- `step=0` freezes `pos` in UP, DOWN and PARK.
- If PARK is entered with `step=0`, it snaps `pos` to min on the next strobe.

**Configuration handshake**
- A transfer occurs when `cfg_vld && cfg_rdy`. The values go into shadow registers and `cfg_rdy` drops.
- Sanitising at capture, in this order:
  1. min = max(cfg_min, 1)
  2. max = max(cfg_max, min)
  3. max is capped at 2^DEL_WIDTH-1
- The pending configuration is applied on the first `smp_i` strictly after the capture cycle. If a capture and `smp_i` occur in the same cycle, the configuration waits for the next strobe.
- The applying strobe performs no step. It loads min, max and step, then does the out-of-range handling described in Configuration. `del_vld` still pulses.
- `cfg_rdy` rises in the cycle after the apply.

## Timing
- Reset values:
  - `pos = RST_MIN_DEL<<F`
  - `del_o = RST_MIN_DEL`
  - state IDLE
  - `del_vld`, `cyc_o` = 0
  - `cfg_rdy` = 1
  - shadow registers cleared; any pending configuration is dropped
- Reset asserted mid-sweep returns all of the above within 1 cycle.
- Latency: `del_o`, `del_vld` and `cyc_o` are registered and valid 1 cycle after `smp_i`. `del_o` is stable between strobes.
- `smp_i` must be separated by at least 2 cycles. Back-to-back strobes give undefined results.
- Every `smp_i` produces exactly one `del_vld`, including in IDLE, where `del_o` repeats min.

## Configuration
Macro `FLG_SWEEP_SLEW_EN` controls how the applying strobe handles a position outside the new [min,max] range.
- **Defined:**
  - `pos > max<<F`: state forced to DOWN.
  - `pos < min<<F`: state forced to UP.
  - The tap then slews into range at the step rate, with bound checks as above.
  - In IDLE/PARK, `pos` is snapped to the new min.
- **Undefined:**
  - `pos` is clamped immediately into [min<<F, max<<F].
  - The direction is unchanged.

## Test plan
- **Reset sweep:** reset, `en`=1, strobe every 4 cycles -> `del_o` rises 16,16,17,17,… (step 64 = 0.5/sample), reaches 255 after 478 strobes, turns down, and `cyc_o` pulses when `del_o` returns to 16.
- **Configuration sanitising:** send `cfg_min`=0, `cfg_max`=0, `cfg_step`=128 -> min=1, max=1, and `del_o` holds 1 with `cyc_o` pulsing every other strobe.
- **Capture coincident with strobe:** capture in the same cycle as `smp_i` -> the new values take effect only at the following strobe, and `cfg_rdy` stays low until the cycle after that.
- **Park:** `en`=0 at `del_o`=200, step=512 (4/sample) -> `del_o` 196,192,…,16 in PARK, then IDLE with 16 held and no `cyc_o` pulse.
- **Out-of-range reconfiguration:** `del_o`=200 while UP, apply max=100 ->
  - with `FLG_SWEEP_SLEW_EN`: `del_o` 200, 199.5…, descending.
  - without the macro: 100 on the applying strobe.
- **Reset mid-operation:** `rst` during PARK with a configuration pending -> next cycle `del_o`=16, `cfg_rdy`=1, state IDLE, and the pending configuration is never applied.

Source files
------------

// File: rtl/flg_sweep_ctrl.sv
// Flanger delay-sweep controller: triangle sweep of the var_del tap between a
// programmable min and max delay at a programmable rate, with a valid/ready
// configuration port applied on sample boundaries and a park-to-min sequence.
// Optional build macro FLG_SWEEP_SLEW_EN: when defined, an out-of-range position
// after a reconfiguration slews back at the step rate instead of being clamped.
module flg_sweep_ctrl #(
    parameter int unsigned DEL_WIDTH   = 9,
    parameter int unsigned FRAC_WIDTH  = 7,
    parameter int unsigned STEP_WIDTH  = 12,
    parameter int unsigned RST_MIN_DEL = 16,
    parameter int unsigned RST_MAX_DEL = 255,
    parameter int unsigned RST_STEP    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  smp_i,
    input  logic [DEL_WIDTH-1:0]  cfg_min,
    input  logic [DEL_WIDTH-1:0]  cfg_max,
    input  logic [STEP_WIDTH-1:0] cfg_step,
    input  logic                  cfg_vld,
    output logic                  cfg_rdy,
    output logic [DEL_WIDTH-1:0]  del_o,
    output logic                  del_vld,
    output logic                  cyc_o
);

    localparam int unsigned PW = DEL_WIDTH + FRAC_WIDTH;
    localparam int unsigned XW = PW + 1;

    typedef enum logic [1:0] {StIdle, StUp, StDown, StPark} state_t;

    state_t                state_q;
    logic [PW-1:0]         pos_q;
    logic [DEL_WIDTH-1:0]  min_q, max_q, sh_min_q, sh_max_q;
    logic [STEP_WIDTH-1:0] step_q, sh_step_q;
    logic                  pend_q;

    logic [PW-1:0]         lo, hi, new_lo, new_hi;
    logic [XW-1:0]         up_sum, dn_dif;
    logic                  up_hit, dn_hit;
    logic [DEL_WIDTH-1:0]  san_min, san_max;

    assign lo     = {min_q, {FRAC_WIDTH{1'b0}}};
    assign hi     = {max_q, {FRAC_WIDTH{1'b0}}};
    assign new_lo = {sh_min_q, {FRAC_WIDTH{1'b0}}};
    assign new_hi = {sh_max_q, {FRAC_WIDTH{1'b0}}};

    // Step arithmetic one bit wider so the carry/borrow is visible.
    assign up_sum = {1'b0, pos_q} + XW'(step_q);
    assign dn_dif = {1'b0, pos_q} - XW'(step_q);
    assign up_hit = (up_sum >= {1'b0, hi});
    assign dn_hit = dn_dif[XW-1] || (dn_dif[PW-1:0] <= lo);

    // Sanitise the requested range: min at least 1, max at least min. The cap
    // at 2^DEL_WIDTH-1 holds by construction of the port width.
    always_comb begin
        san_min = (cfg_min == '0) ? DEL_WIDTH'(1) : cfg_min;
        san_max = (cfg_max < san_min) ? san_min : cfg_max;
    end

    assign del_o   = pos_q[PW-1 -: DEL_WIDTH];
    assign cfg_rdy = ~pend_q;

    // Sweep FSM, configuration capture/apply and registered strobe outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pos_q     <= {DEL_WIDTH'(RST_MIN_DEL), {FRAC_WIDTH{1'b0}}};
            min_q     <= DEL_WIDTH'(RST_MIN_DEL);
            max_q     <= DEL_WIDTH'(RST_MAX_DEL);
            step_q    <= STEP_WIDTH'(RST_STEP);
            sh_min_q  <= '0;
            sh_max_q  <= '0;
            sh_step_q <= '0;
            pend_q    <= 1'b0;
            del_vld   <= 1'b0;
            cyc_o     <= 1'b0;
        end else begin
            del_vld <= smp_i;
            cyc_o   <= 1'b0;

            if (cfg_vld && !pend_q) begin
                sh_min_q  <= san_min;
                sh_max_q  <= san_max;
                sh_step_q <= cfg_step;
                pend_q    <= 1'b1;
            end

            if (smp_i) begin
                if (pend_q) begin
                    // Applying strobe: load the new range, no sweep step.
                    pend_q <= 1'b0;
                    min_q  <= sh_min_q;
                    max_q  <= sh_max_q;
                    step_q <= sh_step_q;
`ifdef FLG_SWEEP_SLEW_EN
                    if (state_q == StIdle || state_q == StPark) begin
                        pos_q <= new_lo;
                    end else if (pos_q > new_hi) begin
                        state_q <= StDown;
                    end else if (pos_q < new_lo) begin
                        state_q <= StUp;
                    end
`else
                    if (state_q == StIdle || pos_q < new_lo) begin
                        pos_q <= new_lo;
                    end else if (pos_q > new_hi) begin
                        pos_q <= new_hi;
                    end
`endif
                end else begin
                    unique case (state_q)
                        StIdle: begin
                            pos_q <= lo;
                            if (en) state_q <= StUp;
                        end
                        StUp: begin
                            if (!en) begin
                                state_q <= StPark;
                            end else if (up_hit) begin
                                pos_q   <= hi;
                                state_q <= StDown;
                            end else begin
                                pos_q <= up_sum[PW-1:0];
                            end
                        end
                        StDown: begin
                            if (!en) begin
                                state_q <= StPark;
                            end else if (dn_hit) begin
                                pos_q   <= lo;
                                cyc_o   <= 1'b1;
                                state_q <= StUp;
                            end else begin
                                pos_q <= dn_dif[PW-1:0];
                            end
                        end
                        StPark: begin
                            if (en) begin
                                // Resume the sweep downwards from here.
                                if (dn_hit) begin
                                    pos_q   <= lo;
                                    cyc_o   <= 1'b1;
                                    state_q <= StUp;
                                end else begin
                                    pos_q   <= dn_dif[PW-1:0];
                                    state_q <= StDown;
                                end
                            end else if (step_q == '0 || dn_hit) begin
                                pos_q   <= lo;
                                state_q <= StIdle;
                            end else begin
                                pos_q <= dn_dif[PW-1:0];
                            end
                        end
                        default: state_q <= StIdle;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_flg_sweep_ctrl.sv
// Self-checking bench for flg_sweep_ctrl: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// behavioural sweep model working in plain integer sub-sample units.
module tb_flg_sweep_ctrl;

    localparam int F = 128;  // 2^FRAC_WIDTH
    localparam int M_IDLE = 0, M_RISE = 1, M_FALL = 2, M_PARK = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        smp_i = 1'b0;
    logic [8:0]  cfg_min = '0;
    logic [8:0]  cfg_max = '0;
    logic [11:0] cfg_step = '0;
    logic        cfg_vld = 1'b0;
    logic        cfg_rdy;
    logic [8:0]  del_o;
    logic        del_vld;
    logic        cyc_o;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    flg_sweep_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .smp_i    (smp_i),
        .cfg_min  (cfg_min),
        .cfg_max  (cfg_max),
        .cfg_step (cfg_step),
        .cfg_vld  (cfg_vld),
        .cfg_rdy  (cfg_rdy),
        .del_o    (del_o),
        .del_vld  (del_vld),
        .cyc_o    (cyc_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_min, m_max, m_step, m_pos, m_mode;
    int p_min, p_max, p_step;
    bit m_pend, e_vld, e_cyc;

    function automatic void m_reset();
        m_min = 16; m_max = 255; m_step = 64; m_pos = 16 * F; m_mode = M_IDLE;
        p_min = 0; p_max = 0; p_step = 0; m_pend = 0; e_vld = 0; e_cyc = 0;
    endfunction

    // Move down one step; on reaching min either turn (sweeping) or stop (parking).
    function automatic void m_descend(input bit parking);
        int n;
        n = m_pos - m_step;
        if (n <= m_min * F) begin
            m_pos = m_min * F;
            if (parking) m_mode = M_IDLE;
            else begin
                e_cyc = 1;
                m_mode = M_RISE;
            end
        end else begin
            m_pos = n;
            m_mode = parking ? M_PARK : M_FALL;
        end
    endfunction

    function automatic void m_step_fn(input bit enable);
        case (m_mode)
            M_IDLE: begin
                m_pos = m_min * F;
                if (enable) m_mode = M_RISE;
            end
            M_RISE: begin
                if (!enable) m_mode = M_PARK;
                else if (m_pos + m_step >= m_max * F) begin
                    m_pos = m_max * F;
                    m_mode = M_FALL;
                end else m_pos = m_pos + m_step;
            end
            M_FALL: begin
                if (!enable) m_mode = M_PARK;
                else m_descend(0);
            end
            default: begin
                if (enable) m_descend(0);
                else if (m_step == 0) begin
                    m_pos = m_min * F;
                    m_mode = M_IDLE;
                end else m_descend(1);
            end
        endcase
    endfunction

    function automatic void m_apply();
        m_min = p_min; m_max = p_max; m_step = p_step;
`ifdef FLG_SWEEP_SLEW_EN
        if (m_mode == M_IDLE || m_mode == M_PARK) m_pos = m_min * F;
        else if (m_pos > m_max * F) m_mode = M_FALL;
        else if (m_pos < m_min * F) m_mode = M_RISE;
`else
        if (m_mode == M_IDLE || m_pos < m_min * F) m_pos = m_min * F;
        else if (m_pos > m_max * F) m_pos = m_max * F;
`endif
        m_pend = 0;
    endfunction

    function automatic void m_capture(input int mn, input int mx, input int st);
        p_min = (mn == 0) ? 1 : mn;
        p_max = (mx < p_min) ? p_min : mx;
        if (p_max > 511) p_max = 511;
        p_step = st;
        m_pend = 1;
    endfunction

    // Model advances on the same edge as the DUT, from the same input values.
    always @(posedge clk) begin
        bit old_pend;
        old_pend = m_pend;
        if (rst) m_reset();
        else begin
            e_vld = smp_i;
            e_cyc = 0;
            if (smp_i) begin
                if (old_pend) m_apply();
                else m_step_fn(en);
            end
            if (cfg_vld && !old_pend) m_capture(int'(cfg_min), int'(cfg_max), int'(cfg_step));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model del_o", 32'(del_o), 32'(m_pos / F));
            chk("model del_vld", 32'(del_vld), 32'(e_vld));
            chk("model cyc_o", 32'(cyc_o), 32'(e_cyc));
            chk("model cfg_rdy", 32'(cfg_rdy), 32'(!m_pend));
        end
    end

    // ---------------- stimulus helpers (entered just after a negedge) ----------------
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic strobe(input int gap, output int d, output bit c);
        smp_i = 1'b1;
        @(negedge clk);
        smp_i = 1'b0;
        d = int'(del_o);
        c = cyc_o;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_cfg(input int mn, input int mx, input int st);
        cfg_min = 9'(mn); cfg_max = 9'(mx); cfg_step = 12'(st);
        cfg_vld = 1'b1;
        @(negedge clk);
        cfg_vld = 1'b0;
    endtask

    // Reset, load step 512 in IDLE, then sweep up to del_o=200.
    task automatic climb_to_200();
        int d;
        bit c;
        do_reset();
        en = 1'b0;
        send_cfg(16, 255, 512);
        strobe(3, d, c);
        en = 1'b1;
        strobe(3, d, c);
        for (int i = 0; i < 46; i++) strobe(3, d, c);
        chk("climb del_o", 32'(d), 32'd200);
    endtask

    initial begin
        int d;
        bit c;
        int first_max, first_cyc, cnt;
        int exp4[4];
        int cyc6[6];
        int oor[4];

        @(negedge clk);
        do_reset();
        chk_en = 1'b1;

        // Reset sweep: 16,16,17,17..., max on strobe 479, turn at min on strobe 957.
        chk("reset del_o", 32'(del_o), 32'd16);
        chk("reset cfg_rdy", 32'(cfg_rdy), 32'd1);
        chk("reset del_vld", 32'(del_vld), 32'd0);
        exp4 = '{16, 16, 17, 17};
        en = 1'b1;
        first_max = 0;
        first_cyc = 0;
        for (int k = 1; k <= 960; k++) begin
            strobe(3, d, c);
            if (k <= 4) chk("sweep start", 32'(d), 32'(exp4[k-1]));
            if (d == 255 && first_max == 0) first_max = k;
            if (c && first_cyc == 0) first_cyc = k;
        end
        chk("sweep max strobe", 32'(first_max), 32'd479);
        chk("sweep cyc strobe", 32'(first_cyc), 32'd957);

        // Sanitising: 0/0 becomes min=max=1; cyc_o every other strobe.
        do_reset();
        en = 1'b0;
        send_cfg(0, 0, 128);
        strobe(3, d, c);
        chk("sanitise apply", 32'(d), 32'd1);
        chk("sanitise rdy", 32'(cfg_rdy), 32'd1);
        en = 1'b1;
        cyc6 = '{0, 0, 1, 0, 1, 0};
        for (int i = 0; i < 6; i++) begin
            strobe(3, d, c);
            chk("sanitise del", 32'(d), 32'd1);
            chk("sanitise cyc", 32'(c), 32'(cyc6[i]));
        end

        // Capture in the same cycle as a strobe waits for the following strobe.
        do_reset();
        en = 1'b1;
        strobe(3, d, c);
        cfg_min = 9'd16; cfg_max = 9'd20; cfg_step = 12'd512;
        cfg_vld = 1'b1;
        smp_i = 1'b1;
        @(negedge clk);
        cfg_vld = 1'b0;
        smp_i = 1'b0;
        chk("coinc old step", 32'(del_o), 32'd16);
        chk("coinc rdy low", 32'(cfg_rdy), 32'd0);
        repeat (3) @(negedge clk);
        smp_i = 1'b1;
        chk("coinc rdy pending", 32'(cfg_rdy), 32'd0);
        @(negedge clk);
        smp_i = 1'b0;
        chk("coinc apply del", 32'(del_o), 32'd16);
        chk("coinc rdy after", 32'(cfg_rdy), 32'd1);
        repeat (3) @(negedge clk);
        strobe(3, d, c);
        chk("coinc new max", 32'(d), 32'd20);
        strobe(3, d, c);
        chk("coinc turn del", 32'(d), 32'd16);
        chk("coinc turn cyc", 32'(c), 32'd1);

        // Park from 200 at 4/sample, then IDLE at 16 without cyc_o.
        climb_to_200();
        en = 1'b0;
        strobe(3, d, c);
        chk("park entry", 32'(d), 32'd200);
        for (int i = 1; i <= 46; i++) begin
            strobe(3, d, c);
            chk("park del", 32'(d), 32'(200 - 4 * i));
            chk("park cyc", 32'(c), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            strobe(3, d, c);
            chk("idle hold", 32'(d), 32'd16);
            chk("idle cyc", 32'(c), 32'd0);
        end

        // Out-of-range reconfiguration at 200 while rising, new max 100.
        climb_to_200();
`ifdef FLG_SWEEP_SLEW_EN
        oor = '{200, 199, 199, 198};
`else
        oor = '{100, 100, 99, 99};
`endif
        send_cfg(16, 100, 64);
        for (int i = 0; i < 4; i++) begin
            strobe(3, d, c);
            chk("oor del", 32'(d), 32'(oor[i]));
        end

        // Reset during PARK with a pending configuration drops it.
        do_reset();
        en = 1'b0;
        send_cfg(16, 255, 512);
        strobe(3, d, c);
        en = 1'b1;
        for (int i = 0; i < 11; i++) strobe(3, d, c);
        en = 1'b0;
        strobe(3, d, c);
        strobe(3, d, c);
        chk("pre-rst park", 32'(d), 32'd52);
        send_cfg(50, 300, 4000);
        chk("pre-rst pending", 32'(cfg_rdy), 32'd0);
        do_reset();
        chk("rst del_o", 32'(del_o), 32'd16);
        chk("rst cfg_rdy", 32'(cfg_rdy), 32'd1);
        chk("rst del_vld", 32'(del_vld), 32'd0);
        strobe(3, d, c);
        chk("rst idle min", 32'(d), 32'd16);
        en = 1'b1;
        exp4 = '{16, 16, 17, 17};
        for (int i = 0; i < 4; i++) begin
            strobe(3, d, c);
            chk("rst old cfg", 32'(d), 32'(exp4[i]));
        end

        // Randomized run against the model.
        do_reset();
        cnt = 0;
        for (int t = 0; t < 12000; t++) begin
            rst = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            smp_i = (cnt == 0);
            if (smp_i) cnt = int'($urandom_range(1, 4));
            else cnt = cnt - 1;
            cfg_vld = ($urandom_range(0, 7) == 0);
            if (cfg_vld) begin
                cfg_min = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 40))
                                                      : 9'($urandom_range(0, 511));
                cfg_max = 9'($urandom_range(0, 511));
                case ($urandom_range(0, 9))
                    0:       cfg_step = 12'd0;
                    1, 2, 3: cfg_step = 12'($urandom_range(1, 600));
                    default: cfg_step = 12'($urandom_range(0, 4095));
                endcase
            end
            @(negedge clk);
        end
        rst = 1'b0;
        smp_i = 1'b0;
        cfg_vld = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
